vscalar_opfetch: RTL and testbench

Scalar operand fetch stage that sits directly in front of the vector unit's scalar register file (vs0–vs31) and feeds scalar operands to the vector issue logic. It accepts a valid/ready read request, drives the register file's registered read port, and returns the operand one cycle later. It forwards a same-cycle writeback, because the register file returns old data on read-during-write. It forces vs0 to zero and holds the returned operand stable under downstream back-pressure.

---
 rtl/vscalar_opfetch_pkg.sv | 14 +
 rtl/vscalar_opfetch_hold.sv | 46 ++++
 rtl/vscalar_opfetch.sv | 93 +++++++++
 tb/tb_vscalar_opfetch.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vscalar_opfetch_pkg.sv
// rtl/vscalar_opfetch_pkg.sv - shared scalar operand widths, vs0 index and operand struct
package vscalar_opfetch_pkg;

  localparam int VS_WIDTH       = 32;
  localparam int VS_LOG2NUMREGS = 5;
  localparam int VS_TAGW        = 4;
  localparam int VS0_IDX        = 0;

  typedef struct packed {
    logic [VS_WIDTH-1:0] data;
    logic [VS_TAGW-1:0]  tag;
  } vs_operand_t;

endpackage

// File: rtl/vscalar_opfetch_hold.sv
// rtl/vscalar_opfetch_hold.sv - operand select mux plus the back-pressure hold register
module vscalar_opfetch_hold
  import vscalar_opfetch_pkg::*;
#(
  parameter int WIDTH = VS_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             s1_valid,
  input  logic             s1_zero,
  input  logic             out_ready,
  input  logic             byp_hit,
  input  logic [WIDTH-1:0] byp_data,
  input  logic [WIDTH-1:0] rf_data,
  output logic [WIDTH-1:0] sel_data
);

  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;

  always_comb begin
    sel_data = rf_data;
    if (s1_zero)
      sel_data = '0;
    else if (hold_valid)
      sel_data = hold_data;
    else if (byp_hit)
      sel_data = byp_data;
  end

  // rf_data is only valid the cycle after capture, so freeze it on the first stalled cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (s1_valid) begin
      if (out_ready) begin
        hold_valid <= 1'b0;
      end else if (!hold_valid) begin
        hold_valid <= 1'b1;
        hold_data  <= sel_data;
      end
    end
  end

endmodule

// File: rtl/vscalar_opfetch.sv
// rtl/vscalar_opfetch.sv - scalar operand fetch stage; VSCALAR_OPFETCH_BYPASS_EN enables writeback forwarding
module vscalar_opfetch
  import vscalar_opfetch_pkg::*;
#(
  parameter int WIDTH       = VS_WIDTH,
  parameter int LOG2NUMREGS = VS_LOG2NUMREGS,
  parameter int TAGW        = VS_TAGW
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LOG2NUMREGS-1:0] in_reg,
  input  logic [TAGW-1:0]        in_tag,
  output logic [LOG2NUMREGS-1:0] rf_a_reg,
  output logic                   rf_a_en,
  input  logic [WIDTH-1:0]       rf_a_readdataout,
  input  logic [LOG2NUMREGS-1:0] wb_reg,
  input  logic [WIDTH-1:0]       wb_data,
  input  logic                   wb_we,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [TAGW-1:0]        out_tag
);

  logic            acc;
  logic            in_is_vs0;
  logic            wb_match;
  logic            s1_valid;
  logic            s1_zero;
  logic [TAGW-1:0] s1_tag;
  logic            byp_hit;
  logic [WIDTH-1:0] byp_data;

  assign in_is_vs0 = (in_reg == LOG2NUMREGS'(VS0_IDX));
  assign wb_match  = wb_we & (wb_reg == in_reg) & !in_is_vs0;

`ifdef VSCALAR_OPFETCH_BYPASS_EN
  assign in_ready = !s1_valid | out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else if (acc) begin
      byp_hit  <= wb_match;
      byp_data <= wb_data;
    end
  end
`else
  // The RAM returns stale data on read-during-write; stall one cycle instead of forwarding
  assign in_ready = (!s1_valid | out_ready) & !(in_valid & wb_match);
  assign byp_hit  = 1'b0;
  assign byp_data = wb_data;
`endif

  assign acc      = in_valid & in_ready;
  assign rf_a_reg = in_reg;
  assign rf_a_en  = acc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_zero  <= 1'b0;
      s1_tag   <= '0;
    end else if (acc) begin
      s1_valid <= 1'b1;
      s1_zero  <= in_is_vs0;
      s1_tag   <= in_tag;
    end else if (out_ready) begin
      s1_valid <= 1'b0;
    end
  end

  vscalar_opfetch_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .resetn   (resetn),
    .s1_valid (s1_valid),
    .s1_zero  (s1_zero),
    .out_ready(out_ready),
    .byp_hit  (byp_hit),
    .byp_data (byp_data),
    .rf_data  (rf_a_readdataout),
    .sel_data (out_data)
  );

  assign out_valid = s1_valid;
  assign out_tag   = s1_tag;

endmodule

// File: tb/tb_vscalar_opfetch.sv
// tb/tb_vscalar_opfetch.sv - scoreboard bench for vscalar_opfetch with a behavioural register file
module tb_vscalar_opfetch;
  import vscalar_opfetch_pkg::*;

  logic                      clk = 1'b0;
  logic                      resetn = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [VS_LOG2NUMREGS-1:0] in_reg = '0;
  logic [VS_TAGW-1:0]        in_tag = '0;
  logic [VS_LOG2NUMREGS-1:0] rf_a_reg;
  logic                      rf_a_en;
  logic [VS_WIDTH-1:0]       rf_a_readdataout = '0;
  logic [VS_LOG2NUMREGS-1:0] wb_reg = '0;
  logic [VS_WIDTH-1:0]       wb_data = '0;
  logic                      wb_we = 1'b0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [VS_WIDTH-1:0]       out_data;
  logic [VS_TAGW-1:0]        out_tag;

  int checks = 0;
  int errors = 0;

  logic [VS_WIDTH-1:0] mem      [32];
  logic [VS_WIDTH-1:0] ref_regs [32];
  vs_operand_t         exp_q[$];

  vscalar_opfetch dut (
    .clk             (clk),
    .resetn          (resetn),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_reg          (in_reg),
    .in_tag          (in_tag),
    .rf_a_reg        (rf_a_reg),
    .rf_a_en         (rf_a_en),
    .rf_a_readdataout(rf_a_readdataout),
    .wb_reg          (wb_reg),
    .wb_data         (wb_data),
    .wb_we           (wb_we),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_tag         (out_tag)
  );

  always #5 clk = ~clk;

  // Registered-read RAM: old data on read-during-write, junk on cycles without a read
  always @(posedge clk) begin
    if (rf_a_en) rf_a_readdataout <= mem[rf_a_reg];
    else         rf_a_readdataout <= $urandom;
    if (wb_we) mem[wb_reg] <= wb_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Drive one cycle; at the falling edge record the write and any acceptance into the model
  task automatic cyc(input logic iv, input logic [4:0] ir, input logic [3:0] it, input logic orr,
                     input logic we, input logic [4:0] wr, input logic [31:0] wd);
    vs_operand_t e;
    @(posedge clk);
    #1;
    in_valid = iv; in_reg = ir; in_tag = it; out_ready = orr;
    wb_we = we; wb_reg = wr; wb_data = wd;
    @(negedge clk);
    if (we) ref_regs[wr] = wd;
    if (iv && in_ready) begin
      e.data = (ir == 5'd0) ? 32'd0 : ref_regs[ir];
      e.tag  = it;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 4'd0, 1'b1, 1'b0, 5'd0, 32'd0);
  endtask

  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      vs_operand_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_operand: got data=%0h tag=%0h with nothing expected", out_data, out_tag);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || out_tag !== e.tag) begin
          errors++;
          $display("FAIL operand: got data=%0h tag=%0h expected data=%0h tag=%0h",
                   out_data, out_tag, e.data, e.tag);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      ref_regs[i] = mem[i];
    end
    #12;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_tag", {28'd0, out_tag}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_rf_a_en", {31'd0, rf_a_en}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Write then read vs5
    cyc(1'b0, 5'd0, 4'd0, 1'b1, 1'b1, 5'd5, 32'h1234);
    idle(1);
    cyc(1'b1, 5'd5, 4'd9, 1'b1, 1'b0, 5'd0, 32'd0);
    cyc(1'b0, 5'd0, 4'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    idle(2);

    // Same-cycle hazard on vs7
    cyc(1'b0, 5'd0, 4'd0, 1'b1, 1'b1, 5'd7, 32'd0);
    idle(1);
    cyc(1'b1, 5'd7, 4'd3, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF);
`ifdef VSCALAR_OPFETCH_BYPASS_EN
    check("hazard_in_ready", {31'd0, in_ready}, 32'd1);
`else
    check("hazard_interlock", {31'd0, in_ready}, 32'd0);
    cyc(1'b1, 5'd7, 4'd3, 1'b1, 1'b0, 5'd0, 32'd0);
    check("hazard_retry", {31'd0, in_ready}, 32'd1);
`endif
    idle(2);

    // vs0 always reads zero, even with a same-cycle write to it
    cyc(1'b0, 5'd0, 4'd0, 1'b1, 1'b1, 5'd0, 32'hFFFF);
    cyc(1'b1, 5'd0, 4'd1, 1'b1, 1'b0, 5'd0, 32'd0);
    cyc(1'b1, 5'd0, 4'd2, 1'b1, 1'b1, 5'd0, 32'hFFFF);
    check("vs0_no_interlock", {31'd0, in_ready}, 32'd1);
    idle(2);

    // Stall with later writes to the same register
    cyc(1'b0, 5'd0, 4'd0, 1'b1, 1'b1, 5'd3, 32'hA);
    idle(1);
    cyc(1'b1, 5'd3, 4'd4, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 5'd6, 4'd5, 1'b0, 1'b1, 5'd3, 32'hB + i);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_rf_a_en", {31'd0, rf_a_en}, 32'd0);
      check("stall_out_data", out_data, 32'hA);
    end
    idle(2);

    // Streaming reads of vs1..vs4
    for (int r = 1; r <= 4; r++) cyc(1'b0, 5'd0, 4'd0, 1'b1, 1'b1, 5'(r), 32'h100 + r);
    idle(1);
    for (int r = 1; r <= 5; r++) begin
      cyc(r <= 4, 5'(r), 4'(r), 1'b1, 1'b0, 5'd0, 32'd0);
      if (r <= 4) check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      if (r >= 2) check("stream_out_valid", {31'd0, out_valid}, 32'd1);
    end
    idle(2);

    // Asynchronous reset while stalled
    cyc(1'b1, 5'd2, 4'd6, 1'b0, 1'b0, 5'd0, 32'd0);
    cyc(1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_reset_out_tag", {28'd0, out_tag}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    #2 resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 5'd0, 4'd0, 1'b1, 1'b0, 5'd0, 32'd0);
      check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("post_reset_no_stale", {31'd0, out_valid}, 32'd0);
    end

    // Random traffic with frequent hazards and back-pressure
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), 4'($urandom),
          $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("drain_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
